// File: rtl/mem_stage.sv
// MEM pipeline stage: req/ack data-memory access with byte-lane steering and load extension.
// Optional misaligned-access trapping is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic [1:0]            in_mem_size,
    input  logic                  in_mem_signed,
    input  logic                  in_write_reg,
    input  logic                  in_mem_to_reg,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_store_data,
    input  logic [REG_ADDR_W-1:0] in_reg_des,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  m_write_reg,
    output logic                  m_mem_to_reg,
    output logic [DATA_W-1:0]     data_from_mem,
    output logic [DATA_W-1:0]     alu_result,
    output logic [REG_ADDR_W-1:0] reg_des,
    output logic                  misalign
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_next;

    logic [DATA_W-1:0]     alu_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic                  we_q;
    logic [DATA_W-1:0]     sdata_q;
    logic                  wr_q;
    logic                  mtr_q;
    logic [REG_ADDR_W-1:0] rd_q;

    logic mem_op;
    logic misaligned_in;
    logic misaligned_op;
    logic start;
    logic busy;

    assign mem_op = in_valid & (in_mem_read | in_mem_write);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned_in = ((in_mem_size == 2'b01) & in_alu_result[0]) |
                           (in_mem_size[1] & (in_alu_result[1:0] != 2'b00));
`else
    assign misaligned_in = 1'b0;
`endif

    assign misaligned_op = mem_op & misaligned_in;
    assign start         = (state == IDLE) & mem_op & ~misaligned_in;
    assign busy          = (state == BUSY);

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                stall      = 1'b1;
                state_next = BUSY;
            end
        end else begin
            stall = ~dmem_ack;
            if (dmem_ack) begin
                state_next = IDLE;
            end
        end
        if (rst) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request fields come only from the latched copy so they stay stable while waiting for ack.
    logic [3:0]        be_lat;
    logic [DATA_W-1:0] wdata_lat;

    always_comb begin
        be_lat    = 4'b1111;
        wdata_lat = sdata_q;
        case (size_q)
            2'b00: begin
                be_lat    = 4'b0001 << alu_q[1:0];
                wdata_lat = {4{sdata_q[7:0]}};
            end
            2'b01: begin
                be_lat    = alu_q[1] ? 4'b1100 : 4'b0011;
                wdata_lat = {2{sdata_q[15:0]}};
            end
            default: begin
                be_lat    = 4'b1111;
                wdata_lat = sdata_q;
            end
        endcase
    end

    assign dmem_req   = busy;
    assign dmem_we    = busy & we_q;
    assign dmem_addr  = busy ? {alu_q[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_be    = busy ? be_lat : 4'b0000;
    assign dmem_wdata = busy ? wdata_lat : '0;

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] load_fmt;

    always_comb begin
        case (alu_q[1:0])
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            2'b00:   load_fmt = {{(DATA_W-8){signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_fmt = {{(DATA_W-16){signed_q & ld_half[15]}}, ld_half};
            default: load_fmt = dmem_rdata;
        endcase
    end

    // Starting an access emits a bubble; results leave only on the ack edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_write_reg   <= 1'b0;
            m_mem_to_reg  <= 1'b0;
            data_from_mem <= '0;
            alu_result    <= '0;
            reg_des       <= '0;
            misalign      <= 1'b0;
            alu_q         <= '0;
            size_q        <= 2'b00;
            signed_q      <= 1'b0;
            we_q          <= 1'b0;
            sdata_q       <= '0;
            wr_q          <= 1'b0;
            mtr_q         <= 1'b0;
            rd_q          <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                alu_q         <= in_alu_result;
                size_q        <= in_mem_size;
                signed_q      <= in_mem_signed;
                we_q          <= in_mem_write;
                sdata_q       <= in_store_data;
                wr_q          <= in_valid & in_write_reg;
                mtr_q         <= in_mem_to_reg;
                rd_q          <= in_reg_des;
                m_write_reg   <= 1'b0;
                m_mem_to_reg  <= 1'b0;
                data_from_mem <= '0;
                misalign      <= 1'b0;
            end else begin
                m_write_reg   <= in_valid & in_write_reg & ~misaligned_op;
                m_mem_to_reg  <= in_mem_to_reg & ~misaligned_op;
                data_from_mem <= '0;
                alu_result    <= in_alu_result;
                reg_des       <= in_reg_des;
                misalign      <= misaligned_op;
            end
        end else begin
            misalign <= 1'b0;
            if (dmem_ack) begin
                m_write_reg   <= wr_q;
                m_mem_to_reg  <= mtr_q;
                data_from_mem <= we_q ? '0 : load_fmt;
                alu_result    <= alu_q;
                reg_des       <= rd_q;
            end else begin
                m_write_reg   <= 1'b0;
                m_mem_to_reg  <= 1'b0;
                data_from_mem <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; honours MEM_ALIGN_CHECK_EN like the design.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [1:0]  in_mem_size;
    logic        in_mem_signed;
    logic        in_write_reg;
    logic        in_mem_to_reg;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_reg_des;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        m_write_reg;
    logic        m_mem_to_reg;
    logic [31:0] data_from_mem;
    logic [31:0] alu_result;
    logic [4:0]  reg_des;
    logic        misalign;

    int total;
    int bad;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_mem_size(in_mem_size), .in_mem_signed(in_mem_signed),
        .in_write_reg(in_write_reg), .in_mem_to_reg(in_mem_to_reg),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data), .in_reg_des(in_reg_des),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .m_write_reg(m_write_reg), .m_mem_to_reg(m_mem_to_reg), .data_from_mem(data_from_mem),
        .alu_result(alu_result), .reg_des(reg_des), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        in_valid      = 1'b0;
        in_mem_read   = 1'b0;
        in_mem_write  = 1'b0;
        in_mem_size   = 2'b00;
        in_mem_signed = 1'b0;
        in_write_reg  = 1'b0;
        in_mem_to_reg = 1'b0;
        in_alu_result = 32'h0;
        in_store_data = 32'h0;
        in_reg_des    = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        total++;
        if ({m_write_reg, m_mem_to_reg, misalign, dmem_req, dmem_we, stall} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {m_write_reg, m_mem_to_reg, misalign, dmem_req, dmem_we, stall});
        end
        total++;
        if ({data_from_mem, alu_result, dmem_addr, dmem_wdata} !== 128'h0 || reg_des !== 5'd0 || dmem_be !== 4'b0) begin
            bad++;
            $display("[TB] FAIL reset_data: got data=%h alu=%h rd=%0d addr=%h be=%b expected all zero",
                     data_from_mem, alu_result, reg_des, dmem_addr, dmem_be);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || dmem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL post_reset_stall: got stall=%b req=%b expected 0 0", stall, dmem_req);
        end
    endtask

    task automatic test_alu_op();
        @(negedge clk);
        in_valid      = 1'b1;
        in_write_reg  = 1'b1;
        in_alu_result = 32'h1234;
        in_reg_des    = 5'd7;
        dmem_ack      = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0 || dmem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL alu_stall: got stall=%b req=%b expected 0 0", stall, dmem_req);
        end
        @(negedge clk);
        total++;
        if (m_write_reg !== 1'b1 || alu_result !== 32'h1234 || reg_des !== 5'd7 ||
            data_from_mem !== 32'h0 || m_mem_to_reg !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL alu_pass: got wr=%b alu=%h rd=%0d data=%h mtr=%b stall=%b expected 1 1234 7 0 0 0",
                     m_write_reg, alu_result, reg_des, data_from_mem, m_mem_to_reg, stall);
        end
        dmem_ack = 1'b0;
        clear_inputs();
    endtask

    // Back-to-back loads: next load is presented on the same cycle the previous result appears.
    task automatic test_load_formats();
        logic [31:0] t_addr  [6] = '{32'h103, 32'h202, 32'h101, 32'h200, 32'h300, 32'h402};
        logic [1:0]  t_size  [6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'b00};
        logic        t_sgn   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] t_rdata [6] = '{32'h80FF_FF00, 32'hBEEF_0000, 32'h0000_9A00,
                                     32'h1234_8001, 32'hCAFE_F00D, 32'h007F_0000};
        logic [31:0] t_exp   [6] = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'h0000_009A,
                                     32'hFFFF_8001, 32'hCAFE_F00D, 32'h0000_007F};
        logic [3:0]  t_be    [6] = '{4'b1000, 4'b1100, 4'b0010, 4'b0011, 4'b1111, 4'b0100};
        logic [31:0] t_waddr [6] = '{32'h100, 32'h200, 32'h100, 32'h200, 32'h300, 32'h400};
        int          t_wait  [6] = '{2, 0, 1, 0, 0, 0};
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            in_valid      = 1'b1;
            in_mem_read   = 1'b1;
            in_mem_write  = 1'b0;
            in_mem_size   = t_size[i];
            in_mem_signed = t_sgn[i];
            in_write_reg  = 1'b1;
            in_mem_to_reg = 1'b1;
            in_alu_result = t_addr[i];
            in_reg_des    = 5'(i + 1);
            #1;
            total++;
            if (stall !== 1'b1 || dmem_req !== 1'b0) begin
                bad++;
                $display("[TB] FAIL load%0d_issue: got stall=%b req=%b expected 1 0", i, stall, dmem_req);
            end
            for (int w = 0; w < t_wait[i]; w++) begin
                @(negedge clk);
                total++;
                if (stall !== 1'b1 || dmem_req !== 1'b1 || dmem_be !== t_be[i] ||
                    dmem_addr !== t_waddr[i] || m_write_reg !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL load%0d_wait%0d: got stall=%b req=%b be=%b addr=%h wr=%b expected 1 1 %b %h 0",
                             i, w, stall, dmem_req, dmem_be, dmem_addr, m_write_reg, t_be[i], t_waddr[i]);
                end
            end
            @(negedge clk);
            dmem_ack   = 1'b1;
            dmem_rdata = t_rdata[i];
            #1;
            total++;
            if (stall !== 1'b0 || dmem_req !== 1'b1 || dmem_we !== 1'b0 ||
                dmem_be !== t_be[i] || dmem_addr !== t_waddr[i]) begin
                bad++;
                $display("[TB] FAIL load%0d_ack: got stall=%b req=%b we=%b be=%b addr=%h expected 0 1 0 %b %h",
                         i, stall, dmem_req, dmem_we, dmem_be, dmem_addr, t_be[i], t_waddr[i]);
            end
            @(negedge clk);
            dmem_ack = 1'b0;
            total++;
            if (data_from_mem !== t_exp[i] || m_write_reg !== 1'b1 || m_mem_to_reg !== 1'b1 ||
                reg_des !== 5'(i + 1) || alu_result !== t_addr[i]) begin
                bad++;
                $display("[TB] FAIL load%0d_result: got data=%h wr=%b mtr=%b rd=%0d alu=%h expected %h 1 1 %0d %h",
                         i, data_from_mem, m_write_reg, m_mem_to_reg, reg_des, alu_result,
                         t_exp[i], i + 1, t_addr[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_stores();
        logic [31:0] s_addr  [2] = '{32'h41, 32'h42};
        logic [1:0]  s_size  [2] = '{2'b00, 2'b01};
        logic        s_read  [2] = '{1'b0, 1'b1};
        logic [31:0] s_data  [2] = '{32'h0000_00AB, 32'h1234_5678};
        logic [31:0] s_wdata [2] = '{32'hABAB_ABAB, 32'h5678_5678};
        logic [3:0]  s_be    [2] = '{4'b0010, 4'b1100};
        logic [31:0] s_waddr [2] = '{32'h40, 32'h40};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid      = 1'b1;
            in_mem_read   = s_read[i];
            in_mem_write  = 1'b1;
            in_mem_size   = s_size[i];
            in_mem_to_reg = 1'b0;
            in_write_reg  = 1'b0;
            in_alu_result = s_addr[i];
            in_store_data = s_data[i];
            in_reg_des    = 5'd9;
            @(negedge clk);
            dmem_ack   = 1'b1;
            dmem_rdata = 32'hDEAD_BEEF;
            #1;
            total++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== s_be[i] ||
                dmem_wdata !== s_wdata[i] || dmem_addr !== s_waddr[i]) begin
                bad++;
                $display("[TB] FAIL store%0d_req: got req=%b we=%b be=%b wdata=%h addr=%h expected 1 1 %b %h %h",
                         i, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, s_be[i], s_wdata[i], s_waddr[i]);
            end
            @(negedge clk);
            dmem_ack = 1'b0;
            clear_inputs();
            total++;
            if (m_write_reg !== 1'b0 || data_from_mem !== 32'h0 || alu_result !== s_addr[i] || reg_des !== 5'd9) begin
                bad++;
                $display("[TB] FAIL store%0d_result: got wr=%b data=%h alu=%h rd=%0d expected 0 0 %h 9",
                         i, m_write_reg, data_from_mem, alu_result, reg_des, s_addr[i]);
            end
        end
    endtask

    task automatic test_reset_in_busy();
        @(negedge clk);
        in_valid      = 1'b1;
        in_mem_read   = 1'b1;
        in_mem_size   = 2'b10;
        in_write_reg  = 1'b1;
        in_mem_to_reg = 1'b1;
        in_alu_result = 32'h10;
        in_reg_des    = 5'd4;
        @(negedge clk);
        total++;
        if (dmem_req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rstbusy_req: got %b expected 1", dmem_req);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        #1;
        total++;
        if (dmem_req !== 1'b0 || stall !== 1'b0 || m_write_reg !== 1'b0 || m_mem_to_reg !== 1'b0 ||
            data_from_mem !== 32'h0 || alu_result !== 32'h0 || reg_des !== 5'd0) begin
            bad++;
            $display("[TB] FAIL rstbusy_clear: got req=%b stall=%b wr=%b mtr=%b data=%h alu=%h rd=%0d expected all 0",
                     dmem_req, stall, m_write_reg, m_mem_to_reg, data_from_mem, alu_result, reg_des);
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        total++;
        if (m_write_reg !== 1'b0 || data_from_mem !== 32'h0 || dmem_req !== 1'b0 || reg_des !== 5'd0) begin
            bad++;
            $display("[TB] FAIL rstbusy_late_ack: got wr=%b data=%h req=%b rd=%0d expected 0 0 0 0",
                     m_write_reg, data_from_mem, dmem_req, reg_des);
        end
    endtask

    task automatic test_align();
        @(negedge clk);
        in_valid      = 1'b1;
        in_mem_read   = 1'b1;
        in_mem_size   = 2'b10;
        in_write_reg  = 1'b1;
        in_mem_to_reg = 1'b1;
        in_alu_result = 32'h6;
        in_reg_des    = 5'd5;
`ifdef MEM_ALIGN_CHECK_EN
        #1;
        total++;
        if (stall !== 1'b0 || dmem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL align_issue: got stall=%b req=%b expected 0 0", stall, dmem_req);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++;
        if (misalign !== 1'b1 || m_write_reg !== 1'b0 || m_mem_to_reg !== 1'b0 || dmem_req !== 1'b0 ||
            alu_result !== 32'h6 || reg_des !== 5'd5) begin
            bad++;
            $display("[TB] FAIL align_flag: got mis=%b wr=%b mtr=%b req=%b alu=%h rd=%0d expected 1 0 0 0 6 5",
                     misalign, m_write_reg, m_mem_to_reg, dmem_req, alu_result, reg_des);
        end
        @(negedge clk);
        total++;
        if (misalign !== 1'b0) begin
            bad++;
            $display("[TB] FAIL align_oneshot: got %b expected 0", misalign);
        end
`else
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL align_issue: got stall=%b expected 1", stall);
        end
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1122_3344;
        #1;
        total++;
        if (dmem_addr !== 32'h4 || dmem_be !== 4'b1111 || dmem_req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL align_req: got addr=%h be=%b req=%b expected 00000004 1111 1",
                     dmem_addr, dmem_be, dmem_req);
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        clear_inputs();
        total++;
        if (data_from_mem !== 32'h1122_3344 || misalign !== 1'b0 || m_write_reg !== 1'b1) begin
            bad++;
            $display("[TB] FAIL align_result: got data=%h mis=%b wr=%b expected 11223344 0 1",
                     data_from_mem, misalign, m_write_reg);
        end
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_alu_op();
        test_load_formats();
        test_stores();
        test_reset_in_busy();
        test_align();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
